// File: rtl/icache_line_fill_responder.sv
// ----------------------------------------------------------------------------
// icache_line_fill_responder
//
// L2-side responder for the I-cache line-fill interface. A one-cycle line
// request starts a fill: block_size word reads are issued to a word-wide
// memory port, the in-order responses are assembled into one cache line, and
// the finished line is returned with a one-cycle DATA_FROM_L2_VALID pulse.
// One extra request can wait in a single-entry pending register while a fill
// is in flight; a request arriving while that register is full is dropped.
//
// Ports
//   CLK, RST_N          clock, synchronous active-low reset
//   ADDR_TO_L2_VALID    line request strobe (1-cycle pulse)
//   ADDR_TO_L2          line address (byte address without the line offset)
//   DATA_FROM_L2        assembled line, held until the next fill overwrites it
//   DATA_FROM_L2_VALID  line valid, 1-cycle pulse
//   FILL_ERR            with DATA_FROM_L2_VALID: some beat of the fill errored
//   MEM_RD_VALID        word read request
//   MEM_ADDR            word-aligned byte address of the read
//   MEM_RD_READY        memory accepts the request this cycle
//   MEM_RDATA           read data
//   MEM_RDATA_VALID     read data valid, responses return in request order
//   MEM_RERR            error on this response beat
//   BUSY                fill in progress or a request pending
//
// Assumes block_size is a power of two greater than one and data_width is a
// power-of-two multiple of 8, so line address, word index and byte offset
// tile the byte address exactly.
// ----------------------------------------------------------------------------
module icache_line_fill_responder #(
   parameter int data_width    = 32,
   parameter int address_width = 32,
   parameter int block_size    = 32,
   parameter int offset_width  = $clog2(data_width*block_size/8),
   parameter int cache_width   = block_size*data_width
) (
   input  logic                                  CLK,
   input  logic                                  RST_N,
   input  logic                                  ADDR_TO_L2_VALID,
   input  logic [address_width-offset_width-1:0] ADDR_TO_L2,
   output logic [cache_width-1:0]                DATA_FROM_L2,
   output logic                                  DATA_FROM_L2_VALID,
   output logic                                  FILL_ERR,
   output logic                                  MEM_RD_VALID,
   output logic [address_width-1:0]              MEM_ADDR,
   input  logic                                  MEM_RD_READY,
   input  logic [data_width-1:0]                 MEM_RDATA,
   input  logic                                  MEM_RDATA_VALID,
   input  logic                                  MEM_RERR,
   output logic                                  BUSY
);

   localparam int CNT_W   = $clog2(block_size) + 1;
   localparam int IDX_W   = (block_size > 1) ? $clog2(block_size) : 1;
   localparam int BYTE_W  = $clog2(data_width/8);
   localparam int LINE_AW = address_width - offset_width;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(block_size - 1);
   localparam logic [CNT_W-1:0] NUM_BEATS = CNT_W'(block_size);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                               state_q, state_d;
   logic [LINE_AW-1:0]                   line_addr_q;
   logic                                 pend_vld_q;
   logic [LINE_AW-1:0]                   pend_addr_q;
   logic [CNT_W-1:0]                     issue_cnt_q;
   logic [CNT_W-1:0]                     resp_cnt_q;
   logic                                 err_q;
   logic [block_size-1:0][data_width-1:0] line_q;

   logic             start;
   logic             issue_fire;
   logic             resp_fire;
   logic [CNT_W-1:0] resp_cnt_inc;

   // A fill starts from IDLE on a fresh request or on a waiting pending one.
   assign start      = (state_q == S_IDLE) && (ADDR_TO_L2_VALID || pend_vld_q);
   assign issue_fire = (state_q == S_ISSUE) && MEM_RD_READY;

   // Only beats that belong to an outstanding read of the current fill are
   // taken; this also discards stale beats left over from an aborted fill
   // while the responder sits in IDLE or DONE.
   assign resp_fire  = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                       MEM_RDATA_VALID && (resp_cnt_q < issue_cnt_q);

   assign resp_cnt_inc = resp_cnt_q + CNT_W'(resp_fire);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_ISSUE;
         S_ISSUE: if (issue_fire && (issue_cnt_q == LAST_BEAT)) state_d = S_DRAIN;
         // The beat arriving this cycle counts, so DONE follows the last
         // beat by exactly one cycle.
         S_DRAIN: if (resp_cnt_inc == NUM_BEATS) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      MEM_RD_VALID       = 1'b0;
      MEM_ADDR           = '0;
      DATA_FROM_L2_VALID = 1'b0;
      FILL_ERR           = 1'b0;
      case (state_q)
         S_ISSUE: begin
            MEM_RD_VALID = 1'b1;
            MEM_ADDR     = {line_addr_q, issue_cnt_q[IDX_W-1:0], {BYTE_W{1'b0}}};
         end
         S_DONE: begin
            DATA_FROM_L2_VALID = 1'b1;
            FILL_ERR           = err_q;
         end
         default: ;
      endcase
   end

   assign BUSY         = (state_q != S_IDLE) || pend_vld_q;
   assign DATA_FROM_L2 = line_q;

   // ------------------------------------------------------------------
   // Request capture and pending slot
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         line_addr_q <= '0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (pend_vld_q) begin
            // The older pending request is served first; a request arriving
            // in the same cycle takes over the slot it frees.
            line_addr_q <= pend_addr_q;
            if (ADDR_TO_L2_VALID) pend_addr_q <= ADDR_TO_L2;
            else                  pend_vld_q  <= 1'b0;
         end else if (ADDR_TO_L2_VALID) begin
            line_addr_q <= ADDR_TO_L2;
         end
      end else if (ADDR_TO_L2_VALID && !pend_vld_q) begin
         pend_vld_q  <= 1'b1;
         pend_addr_q <= ADDR_TO_L2;
      end
   end

   // ------------------------------------------------------------------
   // Beat counters, error accumulation and line assembly
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         issue_cnt_q <= '0;
         resp_cnt_q  <= '0;
         err_q       <= 1'b0;
         line_q      <= '0;
      end else if (start) begin
         // Line data is not cleared: it is overwritten beat by beat.
         issue_cnt_q <= '0;
         resp_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         if (issue_fire) issue_cnt_q <= issue_cnt_q + 1'b1;
         if (resp_fire) begin
            resp_cnt_q                     <= resp_cnt_inc;
            err_q                          <= err_q | MEM_RERR;
            line_q[resp_cnt_q[IDX_W-1:0]]  <= MEM_RDATA;
         end
      end
   end

endmodule

// File: tb/tb_icache_line_fill_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_line_fill_responder
//
// Directed bench for icache_line_fill_responder with block_size=4. A small
// memory model answers accepted reads in order after resp_lat cycles with
// data {addr[11:4], 8'hA0+word}, can hold READY low for a number of cycles
// on one beat, and can flag MEM_RERR on one beat. Expected lines, addresses
// and latencies are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_icache_line_fill_responder;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int BS   = 4;
   localparam int OW   = $clog2(DW*BS/8);
   localparam int CWID = BS*DW;
   localparam int LAW  = AW - OW;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic             ADDR_TO_L2_VALID = 1'b0;
   logic [LAW-1:0]   ADDR_TO_L2 = '0;
   logic [CWID-1:0]  DATA_FROM_L2;
   logic             DATA_FROM_L2_VALID;
   logic             FILL_ERR;
   logic             MEM_RD_VALID;
   logic [AW-1:0]    MEM_ADDR;
   logic             MEM_RD_READY = 1'b1;
   logic [DW-1:0]    MEM_RDATA = '0;
   logic             MEM_RDATA_VALID = 1'b0;
   logic             MEM_RERR = 1'b0;
   logic             BUSY;

   always #5 CLK = ~CLK;

   icache_line_fill_responder #(
      .data_width(DW), .address_width(AW), .block_size(BS)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .ADDR_TO_L2_VALID(ADDR_TO_L2_VALID), .ADDR_TO_L2(ADDR_TO_L2),
      .DATA_FROM_L2(DATA_FROM_L2), .DATA_FROM_L2_VALID(DATA_FROM_L2_VALID),
      .FILL_ERR(FILL_ERR),
      .MEM_RD_VALID(MEM_RD_VALID), .MEM_ADDR(MEM_ADDR), .MEM_RD_READY(MEM_RD_READY),
      .MEM_RDATA(MEM_RDATA), .MEM_RDATA_VALID(MEM_RDATA_VALID), .MEM_RERR(MEM_RERR),
      .BUSY(BUSY)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [CWID-1:0] got, input logic [CWID-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // cyc == E right after posedge E
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // memory model configuration, written only by the stimulus block
   int tid        = 0;
   int resp_lat   = 1;
   int stall_beat = -1;
   int stall_n    = 0;
   int err_beat   = -1;

   // model / monitor state, written only by the model block
   typedef struct { logic [AW-1:0] addr; int due; } rsp_t;
   rsp_t            rq[$];
   logic [AW-1:0]   acc_q[$];
   int              v_edge[$];
   logic [CWID-1:0] v_line[$];
   logic            v_err[$];
   int              drain_cnt = 0;
   int              seen_tid  = 0;
   int              stall_used = 0;
   logic [AW-1:0]   stall_addr = '0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {16'd0, a[11:4], 8'hA0 + 8'(a[3:2])};
   endfunction

   always @(negedge CLK) begin
      rsp_t r;
      if (tid != seen_tid) begin
         seen_tid   = tid;
         stall_used = 0;
      end
      // monitor: a pulse seen here is sampled at the next posedge
      if (DATA_FROM_L2_VALID) begin
         v_edge.push_back(cyc + 1);
         v_line.push_back(DATA_FROM_L2);
         v_err.push_back(FILL_ERR);
      end
      if (BUSY && !MEM_RD_VALID && !DATA_FROM_L2_VALID) drain_cnt++;
      // response for this cycle
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         r = rq.pop_front();
         MEM_RDATA_VALID = 1'b1;
         MEM_RDATA       = mem_word(r.addr);
         MEM_RERR        = (int'(r.addr[3:2]) == err_beat);
      end else begin
         MEM_RDATA_VALID = 1'b0;
         MEM_RDATA       = '0;
         MEM_RERR        = 1'b0;
      end
      // request acceptance
      if (MEM_RD_VALID && int'(MEM_ADDR[3:2]) == stall_beat && stall_used < stall_n) begin
         MEM_RD_READY = 1'b0;
         stall_used++;
         stall_addr = MEM_ADDR;
      end else begin
         MEM_RD_READY = 1'b1;
      end
      if (MEM_RD_VALID && MEM_RD_READY) begin
         acc_q.push_back(MEM_ADDR);
         rq.push_back('{MEM_ADDR, cyc + resp_lat});
      end
   end

   // called at a negedge; t is the posedge that samples the request
   task automatic send_req(input logic [LAW-1:0] a, output int t);
      ADDR_TO_L2_VALID = 1'b1;
      ADDR_TO_L2       = a;
      t = cyc + 1;
      @(negedge CLK);
      ADDR_TO_L2_VALID = 1'b0;
   endtask

   task automatic wait_vld(input int n, input string tag);
      int k = 0;
      while (v_edge.size() < n && k < 80) begin
         @(negedge CLK);
         k++;
      end
      chk(tag, CWID'(v_edge.size()), CWID'(n));
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      int t, tb, nv, na, d0, k;
      repeat (3) @(negedge CLK);
      chk("rst_vld",  CWID'(DATA_FROM_L2_VALID), 0);
      chk("rst_err",  CWID'(FILL_ERR), 0);
      chk("rst_rdv",  CWID'(MEM_RD_VALID), 0);
      chk("rst_addr", CWID'(MEM_ADDR), 0);
      chk("rst_busy", CWID'(BUSY), 0);
      chk("rst_data", DATA_FROM_L2, 0);
      RST_N = 1'b1;
      @(negedge CLK);

      // 1) zero-wait fill
      tid = 1; nv = v_edge.size(); na = acc_q.size(); d0 = drain_cnt;
      send_req(28'h800_0000, t);
      chk("t1_busy", CWID'(BUSY), 1);
      wait_vld(nv + 1, "t1_count");
      chk("t1_lat",  CWID'(v_edge[nv] - t), 6);
      chk("t1_line", v_line[nv], 128'h000000A3_000000A2_000000A1_000000A0);
      chk("t1_err",  CWID'(v_err[nv]), 0);
      chk("t1_addrs", {acc_q[na+3], acc_q[na+2], acc_q[na+1], acc_q[na]},
          128'h8000000C_80000008_80000004_80000000);
      chk("t1_drain", CWID'(drain_cnt - d0), 1);
      chk("t1_hold", DATA_FROM_L2, 128'h000000A3_000000A2_000000A1_000000A0);

      // 2) READY low 3 cycles on beat 2
      tid = 2; stall_beat = 2; stall_n = 3; nv = v_edge.size(); na = acc_q.size();
      send_req(28'h800_0001, t);
      wait_vld(nv + 1, "t2_count");
      chk("t2_lat",   CWID'(v_edge[nv] - t), 9);
      chk("t2_stall", CWID'(stall_used), 3);
      chk("t2_hold_addr", CWID'(stall_addr), 32'h8000_0018);
      chk("t2_line",  v_line[nv], 128'h000001A3_000001A2_000001A1_000001A0);
      chk("t2_addrs", {acc_q[na+3], acc_q[na+2], acc_q[na+1], acc_q[na]},
          128'h8000001C_80000018_80000014_80000010);
      stall_beat = -1; stall_n = 0;

      // 3) second request pending, third dropped
      tid = 3; nv = v_edge.size(); na = acc_q.size();
      send_req(28'h800_0002, t);
      send_req(28'h800_0003, tb);
      chk("t3_busy", CWID'(BUSY), 1);
      send_req(28'h800_0004, tb);
      wait_vld(nv + 2, "t3_count");
      repeat (20) @(negedge CLK);
      chk("t3_no_extra", CWID'(v_edge.size()), CWID'(nv + 2));
      chk("t3_acc_cnt",  CWID'(acc_q.size() - na), 8);
      chk("t3_lat_a", CWID'(v_edge[nv] - t), 6);
      chk("t3_lat_b", CWID'(v_edge[nv+1] - t), 13);
      chk("t3_line_a", v_line[nv],   128'h000002A3_000002A2_000002A1_000002A0);
      chk("t3_line_b", v_line[nv+1], 128'h000003A3_000003A2_000003A1_000003A0);
      chk("t3_idle", CWID'(BUSY), 0);

      // 4) error on beat 1, then a clean fill
      tid = 4; err_beat = 1; nv = v_edge.size();
      send_req(28'h800_0005, t);
      wait_vld(nv + 1, "t4_count");
      chk("t4_err",  CWID'(v_err[nv]), 1);
      chk("t4_line", v_line[nv], 128'h000005A3_000005A2_000005A1_000005A0);
      err_beat = -1;
      send_req(28'h800_0006, t);
      wait_vld(nv + 2, "t4_count2");
      chk("t4_err_clean", CWID'(v_err[nv+1]), 0);
      chk("t4_line2", v_line[nv+1], 128'h000006A3_000006A2_000006A1_000006A0);

      // 5) reset during DRAIN
      tid = 5; resp_lat = 3; nv = v_edge.size();
      send_req(28'h800_0007, t);
      k = 0;
      while (!MEM_RD_VALID && k < 20) begin @(negedge CLK); k++; end
      while (MEM_RD_VALID && k < 20) begin @(negedge CLK); k++; end
      chk("t5_in_drain", CWID'(BUSY && !MEM_RD_VALID && !DATA_FROM_L2_VALID), 1);
      RST_N = 1'b0;
      @(negedge CLK);
      chk("t5_rst_data", DATA_FROM_L2, 0);
      chk("t5_rst_busy", CWID'(BUSY), 0);
      chk("t5_rst_rdv",  CWID'(MEM_RD_VALID), 0);
      chk("t5_rst_addr", CWID'(MEM_ADDR), 0);
      chk("t5_rst_vld",  CWID'(DATA_FROM_L2_VALID), 0);
      RST_N = 1'b1;
      repeat (10) @(negedge CLK);
      chk("t5_no_stale_vld", CWID'(v_edge.size()), CWID'(nv));
      resp_lat = 1;
      send_req(28'h800_0008, t);
      wait_vld(nv + 1, "t5_count");
      chk("t5_lat",  CWID'(v_edge[nv] - t), 6);
      chk("t5_line", v_line[nv], 128'h000008A3_000008A2_000008A1_000008A0);

      // 6) responses 5 cycles late, requests accepted back-to-back
      tid = 6; resp_lat = 5; nv = v_edge.size(); d0 = drain_cnt;
      send_req(28'h800_0009, t);
      wait_vld(nv + 1, "t6_count");
      chk("t6_lat",   CWID'(v_edge[nv] - t), 10);
      chk("t6_drain", CWID'(drain_cnt - d0), 5);
      chk("t6_line",  v_line[nv], 128'h000009A3_000009A2_000009A1_000009A0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
